net_rx: RTL and testbench



---
 rtl/net_pkg.sv | 40 ++++
 rtl/net_rx_if.sv | 20 ++
 rtl/net_rx_ddr.sv | 48 ++++
 rtl/net_rx.sv | 169 ++++++++++++++++
 tb/tb_net_rx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/net_pkg.sv
// ---------------------------------------------------------------------------
// net_pkg -- shared definitions for the RGMII receive/transmit path.
//   DATA_W          : stream byte width
//   CNT_W           : frame byte counter width (saturating)
//   PREAMBLE_BYTE   : preamble octet
//   SFD_BYTE        : start-of-frame delimiter
//   CRC_INIT        : CRC-32 register start value
//   CRC_POLY        : reflected CRC-32 polynomial
//   CRC_RESIDUE     : register value after data + correct FCS
//   rx_state_t      : receiver FSM states
//   crc32()         : one-byte, LSB-first CRC-32 register update
// ---------------------------------------------------------------------------
package net_pkg;

    localparam int          DATA_W        = 8;
    localparam int          CNT_W         = 11;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    // Bit-serial reflected CRC-32 over one byte, LSB first.
    function automatic logic [31:0] crc32(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/net_rx_if.sv
// ---------------------------------------------------------------------------
// net_rx_if -- received-frame byte stream (no backpressure).
//   m_data  : frame byte
//   m_valid : m_data valid this cycle
//   m_last  : final byte of frame, qualified by m_valid
//   m_good  : frame passed CRC/length/error checks, qualified by m_last
// Modports: master (producer), slave (consumer).
// ---------------------------------------------------------------------------
interface net_rx_if;
    import net_pkg::*;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_good;

    modport master (output m_data, m_valid, m_last, m_good);
    modport slave  (input  m_data, m_valid, m_last, m_good);

endinterface

// File: rtl/net_rx_ddr.sv
// ---------------------------------------------------------------------------
// net_rx_ddr -- RGMII double-data-rate capture and byte assembly.
//   clk125  in  : RGMII receive clock
//   rst     in  : synchronous active-high reset
//   rxctl   in  : RX_CTL (DV on rising edge, DV^ER on falling edge)
//   rxd     in  : data nibbles (low on rising, high on falling edge)
//   rx_byte out : {falling nibble, rising nibble}, one per clk125
//   rx_dv   out : rising-edge RX_CTL
//   rx_er   out : rising XOR falling RX_CTL
// ---------------------------------------------------------------------------
module net_rx_ddr (
    input  logic       clk125,
    input  logic       rst,
    input  logic       rxctl,
    input  logic [3:0] rxd,
    output logic [7:0] rx_byte,
    output logic       rx_dv,
    output logic       rx_er
);

    logic [3:0] lo_p0;
    logic       dv_p0;
    logic [3:0] hi_p0;
    logic       ctlf_p0;

    // Stage p0 (rising edge): low nibble and DV.
    // Stage p1 (next rising edge): assemble with the falling-edge half.
    always_ff @(posedge clk125) begin
        lo_p0   <= rxd;
        rx_byte <= {hi_p0, lo_p0};
        if (rst) begin
            dv_p0 <= 1'b0;
            rx_dv <= 1'b0;
            rx_er <= 1'b0;
        end else begin
            dv_p0 <= rxctl;
            rx_dv <= dv_p0;
            rx_er <= dv_p0 ^ ctlf_p0;
        end
    end

    // Stage p0 (falling edge): high nibble and DV^ER.
    always_ff @(negedge clk125) begin
        hi_p0   <= rxd;
        ctlf_p0 <= rxctl;
    end

endmodule

// File: rtl/net_rx.sv
// ---------------------------------------------------------------------------
// net_rx -- RGMII Ethernet frame receiver.
// Strips preamble/SFD and FCS, checks CRC-32 residue, frame length and
// RX_ER, and streams frame bytes with a good/bad verdict on the last byte.
//   clk125  in  : RGMII receive clock
//   rst     in  : synchronous active-high reset
//   rxctl   in  : RGMII RX_CTL
//   rxd     in  : RGMII data nibbles
//   m       mst : net_rx_if byte stream (m_data/m_valid/m_last/m_good)
//   ok_cnt  out : frames ending good (wraps)
//   bad_cnt out : frames ending bad (wraps)
// ---------------------------------------------------------------------------
module net_rx
    import net_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk125,
    input  logic        rst,
    input  logic        rxctl,
    input  logic [3:0]  rxd,
    net_rx_if.master    m,
    output logic [15:0] ok_cnt,
    output logic [15:0] bad_cnt
);

    // Delay line depth: 4 FCS bytes plus the byte being emitted, so FCS
    // never reaches the output.
    localparam int              DL_DEPTH = 5;
    localparam logic [CNT_W-1:0] DL_LEN  = CNT_W'(DL_DEPTH);
    localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [DATA_W-1:0] rx_byte;
    logic              rx_dv;
    logic              rx_er;

    rx_state_t         state, state_nxt;
    logic [31:0]       crc, crc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              err, err_nxt;
    logic [DATA_W-1:0] dl [DL_DEPTH];
    logic              shift;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              vld_q, vld_nxt;
    logic              last_q, last_nxt;
    logic              good_q, good_nxt;
    logic              ok_inc, bad_inc;

    net_rx_ddr u_ddr (
        .clk125  (clk125),
        .rst     (rst),
        .rxctl   (rxctl),
        .rxd     (rxd),
        .rx_byte (rx_byte),
        .rx_dv   (rx_dv),
        .rx_er   (rx_er)
    );

    always_ff @(posedge clk125) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        cnt_nxt   = cnt;
        err_nxt   = err;
        shift     = 1'b0;
        data_nxt  = data_q;
        vld_nxt   = 1'b0;
        last_nxt  = 1'b0;
        good_nxt  = 1'b0;
        ok_inc    = 1'b0;
        bad_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) state_nxt = (rx_byte == PREAMBLE_BYTE) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                end else if (rx_byte == SFD_BYTE) begin
                    state_nxt = DATA;
                    crc_nxt   = CRC_INIT;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end else if (rx_byte != PREAMBLE_BYTE) begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (rx_dv) begin
                    crc_nxt = crc32(crc, rx_byte);
                    cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 11'd1;
                    err_nxt = err | rx_er;
                    shift   = 1'b1;
                    // Line is full: the byte falling out is frame data.
                    if (cnt >= DL_LEN) begin
                        vld_nxt  = 1'b1;
                        data_nxt = dl[DL_DEPTH-1];
                        // This byte makes the frame one too long: close it bad.
                        if (cnt == MAX_L) begin
                            last_nxt  = 1'b1;
                            bad_inc   = 1'b1;
                            state_nxt = DROP;
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                    // Oldest entry is the last payload byte; the rest is FCS.
                    if (cnt > DL_LEN) begin
                        vld_nxt  = 1'b1;
                        data_nxt = dl[DL_DEPTH-1];
                        last_nxt = 1'b1;
                        good_nxt = (crc == CRC_RESIDUE) && (cnt >= MIN_L) &&
                                   (cnt <= MAX_L) && !err;
                        ok_inc   = good_nxt;
                        bad_inc  = !good_nxt;
                    end else begin
                        bad_inc = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            crc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            for (int i = 0; i < DL_DEPTH; i++) dl[i] <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            good_q  <= 1'b0;
            ok_cnt  <= '0;
            bad_cnt <= '0;
        end else begin
            crc    <= crc_nxt;
            cnt    <= cnt_nxt;
            err    <= err_nxt;
            data_q <= data_nxt;
            vld_q  <= vld_nxt;
            last_q <= last_nxt;
            good_q <= good_nxt;
            if (shift) begin
                dl[0] <= rx_byte;
                for (int i = 1; i < DL_DEPTH; i++) dl[i] <= dl[i-1];
            end
            if (ok_inc)  ok_cnt  <= ok_cnt + 16'd1;
            if (bad_inc) bad_cnt <= bad_cnt + 16'd1;
        end
    end

    assign m.m_data  = data_q;
    assign m.m_valid = vld_q;
    assign m.m_last  = last_q;
    assign m.m_good  = good_q;

endmodule

// File: tb/tb_net_rx.sv
module tb_net_rx;

    logic        clk125 = 1'b0;
    logic        rst;
    logic        rxctl;
    logic [3:0]  rxd;
    logic [15:0] ok_cnt;
    logic [15:0] bad_cnt;

    net_rx_if rx_if ();

    net_rx #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk125  (clk125),
        .rst     (rst),
        .rxctl   (rxctl),
        .rxd     (rxd),
        .m       (rx_if),
        .ok_cnt  (ok_cnt),
        .bad_cnt (bad_cnt)
    );

    always #4 clk125 = ~clk125;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       good;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] frm[$];
    logic [7:0] hdr [14] = '{8'h08, 8'hBF, 8'hB8, 8'hDA, 8'h00, 8'h1A, 8'h2B,
                             8'h3C, 8'h4D, 8'h5E, 8'h5F, 8'h60, 8'h08, 8'h00};
    int         errors = 0;
    int         checks = 0;
    logic       loose;
    logic [7:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, called once per cycle at the falling edge.
    task automatic sample();
        exp_t e;
        if (rx_if.m_valid === 1'b1) begin
            if (loose) begin
                chk("abandoned_no_last", 32'(rx_if.m_last), 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(rx_if.m_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", 32'(rx_if.m_data), 32'(e.d));
                chk("m_last", 32'(rx_if.m_last), 32'(e.last));
                if (e.last) chk("m_good", 32'(rx_if.m_good), 32'(e.good));
            end
            last_data = rx_if.m_data;
        end else if (!loose) begin
            chk("m_valid_idle", 32'(rx_if.m_valid), 32'd0);
            chk("m_data_hold", 32'(rx_if.m_data), 32'(last_data));
        end
    endtask

    // One RGMII byte per clock: low nibble + DV for the rising edge,
    // high nibble + DV^ER for the falling edge.
    task automatic send_byte(input logic [7:0] b, input logic dv, input logic er);
        @(negedge clk125);
        sample();
        #1;
        rxd   = b[3:0];
        rxctl = dv;
        @(posedge clk125);
        #1;
        rxd   = b[7:4];
        rxctl = dv ^ er;
    endtask

    task automatic gap();
        repeat (12) send_byte(8'h00, 1'b0, 1'b0);
        chk("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ q[k][j];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    task automatic build_frame(input int n_payload);
        logic [31:0] fcs;
        frm.delete();
        foreach (hdr[k]) frm.push_back(hdr[k]);
        repeat (n_payload) frm.push_back(8'h39);
        fcs = ~ref_crc(frm);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic expect_frame(input int n, input logic good);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.d    = frm[k];
            e.last = (k == n - 1);
            e.good = good;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int er_at, input int rst_at);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_at) begin
                rst   = 1'b1;
                loose = 1'b1;
                repeat (3) send_byte(8'h00, 1'b0, 1'b0);
                rst       = 1'b0;
                exp_q.delete();
                last_data = 8'h00;
                loose     = 1'b0;
                return;
            end
            send_byte(frm[i], 1'b1, (i == er_at));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rxctl     = 1'b0;
        rxd       = 4'h0;
        loose     = 1'b1;
        last_data = 8'h00;
        repeat (3) send_byte(8'h00, 1'b0, 1'b0);
        chk("rst_m_valid", 32'(rx_if.m_valid), 32'd0);
        chk("rst_m_last", 32'(rx_if.m_last), 32'd0);
        chk("rst_m_good", 32'(rx_if.m_good), 32'd0);
        chk("rst_m_data", 32'(rx_if.m_data), 32'd0);
        chk("rst_ok_cnt", 32'(ok_cnt), 32'd0);
        chk("rst_bad_cnt", 32'(bad_cnt), 32'd0);
        rst   = 1'b0;
        loose = 1'b0;
        repeat (4) send_byte(8'h00, 1'b0, 1'b0);

        // Loopback frame: 14-byte header + 200 x 0x39 + FCS.
        build_frame(200);
        chk("frame_len", 32'(frm.size()), 32'd218);
        expect_frame(214, 1'b1);
        send_frame(-1, -1);
        gap();
        chk("good_ok_cnt", 32'(ok_cnt), 32'd1);
        chk("good_bad_cnt", 32'(bad_cnt), 32'd0);

        // Same frame with one FCS byte corrupted.
        build_frame(200);
        frm[215] = frm[215] ^ 8'h01;
        expect_frame(214, 1'b0);
        send_frame(-1, -1);
        gap();
        chk("badfcs_ok_cnt", 32'(ok_cnt), 32'd1);
        chk("badfcs_bad_cnt", 32'(bad_cnt), 32'd1);

        // Runt: valid CRC, 60 bytes total.
        build_frame(42);
        expect_frame(56, 1'b0);
        send_frame(-1, -1);
        gap();
        chk("runt_bad_cnt", 32'(bad_cnt), 32'd2);

        // RX_ER in the payload, then a clean frame.
        build_frame(200);
        expect_frame(214, 1'b0);
        send_frame(100, -1);
        gap();
        chk("er_bad_cnt", 32'(bad_cnt), 32'd3);
        build_frame(200);
        expect_frame(214, 1'b1);
        send_frame(-1, -1);
        gap();
        chk("clean_ok_cnt", 32'(ok_cnt), 32'd2);

        // Three bytes after SFD: nothing out, counted bad.
        frm.delete();
        frm.push_back(8'h01);
        frm.push_back(8'h02);
        frm.push_back(8'h03);
        send_frame(-1, -1);
        gap();
        chk("short_bad_cnt", 32'(bad_cnt), 32'd4);
        chk("short_ok_cnt", 32'(ok_cnt), 32'd2);

        // Corrupt SFD: whole burst ignored.
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h5D, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'hAA, 1'b1, 1'b0);
        gap();
        chk("badsfd_ok_cnt", 32'(ok_cnt), 32'd2);
        chk("badsfd_bad_cnt", 32'(bad_cnt), 32'd4);

        // Oversize: 1530 bytes; closed bad when count hits 1519.
        frm.delete();
        for (int i = 0; i < 1530; i++) frm.push_back(i[7:0]);
        expect_frame(1514, 1'b0);
        send_frame(-1, -1);
        gap();
        chk("long_bad_cnt", 32'(bad_cnt), 32'd5);

        // Reset at byte 100 of a frame, then a good frame.
        build_frame(200);
        loose = 1'b1;
        send_frame(-1, 100);
        gap();
        chk("rstmid_ok_cnt", 32'(ok_cnt), 32'd0);
        chk("rstmid_bad_cnt", 32'(bad_cnt), 32'd0);
        build_frame(200);
        expect_frame(214, 1'b1);
        send_frame(-1, -1);
        gap();
        chk("after_rst_ok_cnt", 32'(ok_cnt), 32'd1);
        chk("after_rst_bad_cnt", 32'(bad_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
